// File: rtl/cached_fetcher.sv
// cached_fetcher: instruction fetch stage with a direct-mapped one-instruction-per-line cache
// in front of the program-memory valid/ready read channel.
module cached_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 16,
    parameter int COUNTER_BITS          = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNTER_BITS-1:0]          hit_count,
    output logic [COUNTER_BITS-1:0]          miss_count
);
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int A = PROGRAM_MEM_ADDR_BITS;
    localparam logic [2:0] IDLE        = 3'b000;
    localparam logic [2:0] FETCHING    = 3'b001;
    localparam logic [2:0] FETCHED     = 3'b010;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    logic [CACHE_LINES-1:0]           line_valid;
    logic [A-IDX_BITS-1:0]            line_tag  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_LINES];
    logic [IDX_BITS-1:0]              pc_idx;
    logic [IDX_BITS-1:0]              fill_idx;
    logic                             hit;
    logic                             fill;

    assign pc_idx   = current_pc[IDX_BITS-1:0];
    assign fill_idx = mem_read_address[IDX_BITS-1:0];
    // An invalidate arriving with the lookup must not see the lines it is about to clear.
    assign hit  = line_valid[pc_idx] && !cache_invalidate &&
                  line_tag[pc_idx] == current_pc[A-1:IDX_BITS];
    assign fill = fetcher_state == FETCHING && mem_read_ready;

    always_ff @(posedge clk) begin
        if (!reset && fill) begin
            line_tag[fill_idx]  <= mem_read_address[A-1:IDX_BITS];
            line_data[fill_idx] <= mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetcher_state    <= IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
            line_valid       <= '0;
        end else begin
            if (cache_invalidate)
                line_valid <= '0;
            case (fetcher_state)
                IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (hit) begin
                            instruction   <= line_data[pc_idx];
                            fetcher_state <= FETCHED;
                            if (~&hit_count)
                                hit_count <= hit_count + COUNTER_BITS'(1);
                        end else begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= current_pc;
                            fetcher_state    <= FETCHING;
                            if (~&miss_count)
                                miss_count <= miss_count + COUNTER_BITS'(1);
                        end
                    end
                end
                FETCHING: begin
                    if (mem_read_ready) begin
                        instruction    <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        fetcher_state  <= FETCHED;
                        if (!cache_invalidate)
                            line_valid[fill_idx] <= 1'b1;
                    end
                end
                FETCHED: begin
                    if (core_state == CORE_DECODE)
                        fetcher_state <= IDLE;
                end
                default: begin
                    fetcher_state  <= IDLE;
                    mem_read_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
